vote_session_ctrl: RTL and testbench
====================================

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: number of cycles the OPEN window lasts before a forced close; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to open a voting session; honoured only in IDLE.
REQ-005 vote_en  input  4  per-voter ballot strobe; bit i belongs to voter i.
REQ-006 vote_val  input  4  per-voter ballot value, 1 = yes, 0 = no; sampled when the matching vote_en bit is 1.
REQ-007 busy  output  1  high in OPEN and TALLY.
REQ-008 voted  output  4  bit i set once voter i's ballot is latched in the current session.
REQ-009 yes_cnt  output  3  yes ballots in the last completed session, 0..4.
REQ-010 no_cnt  output  3  no ballots in the last completed session, 0..4.
REQ-011 pass  output  1  high when yes_cnt >= 3 (strict majority of four).
REQ-012 tie  output  1  high when yes_cnt == 2 and no_cnt == 2.
REQ-013 done  output  1  one-cycle pulse marking that a session's results have just been updated.

Function
REQ-014 FSM states IDLE, OPEN, TALLY, DONE, with DONE lasting exactly one cycle.
REQ-015 IDLE -> OPEN on start == 1; on that edge voted, the ballot register and the window counter clear to 0.
REQ-016 In OPEN, every cycle, each voter i with vote_en[i] == 1 and voted[i] == 0 latches vote_val[i] and sets voted[i]; several voters may latch in the same cycle.
REQ-017 A vote_en[i] pulse for a voter whose voted[i] == 1 is ignored: no re-vote, no error.
REQ-018 vote_en in IDLE, TALLY or DONE is ignored.
REQ-019 OPEN -> TALLY on the edge where voted becomes 4'b1111, including the ballots latched on that same edge.
REQ-020 The window counter increments each OPEN cycle; OPEN -> TALLY on the edge where the counter equals TIMEOUT-1, with ballots strobed on that cycle still latched.
REQ-021 Voters without voted set at close are abstentions and count in neither yes_cnt nor no_cnt.
REQ-022 TALLY lasts one cycle; on exit, yes_cnt = popcount(ballot & voted), no_cnt = popcount(~ballot & voted), pass and tie are recomputed from these values, and the FSM enters DONE.
REQ-023 done = 1 exactly in the DONE cycle, which is the first cycle the new results are visible; DONE -> IDLE unconditionally.
REQ-024 yes_cnt, no_cnt, pass, tie and voted hold their values from DONE through IDLE until the next start; voted holds until it is cleared by REQ-015.
REQ-025 start in OPEN, TALLY or DONE is ignored and does not restart the window.
REQ-026 Latency: start sampled on edge N gives busy = 1 from N; if all four voters strobe in the first OPEN cycle, TALLY is the next cycle and done follows one cycle after TALLY.
REQ-027 The window counter is 8 bits and never wraps, because forced close occurs at TIMEOUT-1.

Reset
REQ-028 While rst = 1, state = IDLE, and busy, done, pass, tie, voted, yes_cnt, no_cnt, the ballot register and the window counter are all 0, independent of clk.
REQ-029 Reset asserted mid-session discards all latched ballots; after release, no done pulse occurs until a new start.

Verification
REQ-030 Full vote: start, then one cycle vote_en=1111, vote_val=1011 -> TALLY next cycle, then done with yes_cnt=3, no_cnt=1, pass=1, tie=0.
REQ-031 Tie: voters strobed across separate cycles with values 1,0,1,0 -> done with yes_cnt=2, no_cnt=2, pass=0, tie=1.
REQ-032 Timeout with abstention, TIMEOUT=16: only voters 0 and 1 vote yes -> forced close 16 cycles after start with yes_cnt=2, no_cnt=0, pass=0, tie=0, voted=0011.
REQ-033 Re-vote and late start: voter 2 strobes yes then no, and start pulses mid-OPEN -> ballot 2 stays yes, and the session is not restarted.
REQ-034 Reset mid-OPEN after two ballots -> all outputs 0 immediately; a following start/full-vote session reports only the new ballots.
REQ-035 Back-to-back sessions: start asserted in the IDLE cycle right after done -> new session opens, and the previous results hold until the new done.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Four-voter ballot session controller: opens a window on start, latches one
// ballot per voter, closes on full turnout or timeout, then publishes the tally.
module vote_session_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_en,
  input  logic [3:0] vote_val,
  output logic       busy,
  output logic [3:0] voted,
  output logic [2:0] yes_cnt,
  output logic [2:0] no_cnt,
  output logic       pass,
  output logic       tie,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_TALLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CYC = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] voted_q;
  logic [3:0] ballot_q;
  logic [7:0] win_cnt_q;
  logic [2:0] yes_q;
  logic [2:0] no_q;
  logic       pass_q;
  logic       tie_q;
  logic       done_q;
  logic       busy_q;

  logic [3:0] accept_d;
  logic [3:0] voted_d;
  logic [3:0] ballot_d;
  logic       close_d;
  logic [2:0] yes_d;
  logic [2:0] no_d;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Only a voter's first strobe in a session is accepted; later ones are dropped.
  always_comb begin
    accept_d = vote_en & ~voted_q;
    voted_d  = voted_q | accept_d;
    ballot_d = (ballot_q & ~accept_d) | (vote_val & accept_d);
    close_d  = (voted_d == 4'b1111) || (win_cnt_q == LAST_CYC);
    yes_d    = popcount4(ballot_q & voted_q);
    no_d     = popcount4(~ballot_q & voted_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      voted_q   <= 4'b0000;
      ballot_q  <= 4'b0000;
      win_cnt_q <= 8'd0;
      yes_q     <= 3'd0;
      no_q      <= 3'd0;
      pass_q    <= 1'b0;
      tie_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_OPEN;
            busy_q    <= 1'b1;
            voted_q   <= 4'b0000;
            ballot_q  <= 4'b0000;
            win_cnt_q <= 8'd0;
          end
        end
        S_OPEN: begin
          voted_q   <= voted_d;
          ballot_q  <= ballot_d;
          win_cnt_q <= win_cnt_q + 8'd1;
          if (close_d) begin
            state_q <= S_TALLY;
          end
        end
        S_TALLY: begin
          yes_q   <= yes_d;
          no_q    <= no_d;
          pass_q  <= (yes_d >= 3'd3);
          tie_q   <= (yes_d == 3'd2) && (no_d == 3'd2);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign voted   = voted_q;
  assign yes_cnt = yes_q;
  assign no_cnt  = no_q;
  assign pass    = pass_q;
  assign tie     = tie_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed and randomized sessions for vote_session_ctrl, checked against a
// per-session model built from each voter's first strobe in the window.
module tb_vote_session_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_en;
  logic [3:0] vote_val;
  logic       busy;
  logic [3:0] voted;
  logic [2:0] yes_cnt;
  logic [2:0] no_cnt;
  logic       pass;
  logic       tie;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  // Results of the last completed session as the bench expects them.
  int         exp_yes   = 0;
  int         exp_no    = 0;
  logic [3:0] exp_voted = 4'b0000;

  // Per-OPEN-cycle stimulus for the next session.
  logic [3:0] en_seq  [TO];
  logic [3:0] val_seq [TO];
  logic       st_seq  [TO];

  always #5 clk = ~clk;

  vote_session_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vote_en  (vote_en),
    .vote_val (vote_val),
    .busy     (busy),
    .voted    (voted),
    .yes_cnt  (yes_cnt),
    .no_cnt   (no_cnt),
    .pass     (pass),
    .tie      (tie),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic d,
                         input logic [3:0] v, input int y, input int n);
    chk({tag, ".busy"},  8'(busy),    8'(b));
    chk({tag, ".done"},  8'(done),    8'(d));
    chk({tag, ".voted"}, 8'(voted),   8'(v));
    chk({tag, ".yes"},   8'(yes_cnt), 8'(y));
    chk({tag, ".no"},    8'(no_cnt),  8'(n));
    chk({tag, ".pass"},  8'(pass),    8'(y >= 3));
    chk({tag, ".tie"},   8'(tie),     8'((y == 2) && (n == 2)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    for (int k = 0; k < TO; k++) begin
      en_seq[k]  = 4'b0000;
      val_seq[k] = 4'b0000;
      st_seq[k]  = 1'b0;
    end
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE; start is issued at once.
  task automatic run_session(input string tag, input bit extra_idle);
    int         first_k [4];
    int         close_k;
    int         ny;
    int         nn;
    logic [3:0] fin;
    logic [3:0] vexp;

    for (int i = 0; i < 4; i++) begin
      first_k[i] = 1000;
      for (int k = TO - 1; k >= 0; k--) begin
        if (en_seq[k][i]) first_k[i] = k;
      end
    end
    close_k = first_k[0];
    for (int i = 1; i < 4; i++) begin
      if (first_k[i] > close_k) close_k = first_k[i];
    end
    if (close_k > TO - 1) close_k = TO - 1;
    ny  = 0;
    nn  = 0;
    fin = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (first_k[i] <= close_k) begin
        fin[i] = 1'b1;
        if (val_seq[first_k[i]][i]) ny++;
        else nn++;
      end
    end

    start    = 1'b1;
    vote_en  = 4'($urandom);
    vote_val = 4'($urandom);
    tick();
    chk_all({tag, ".open"}, 1'b1, 1'b0, 4'b0000, exp_yes, exp_no);

    for (int k = 0; k <= close_k; k++) begin
      start    = st_seq[k];
      vote_en  = en_seq[k];
      vote_val = val_seq[k];
      tick();
      vexp = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (first_k[i] <= k) vexp[i] = 1'b1;
      end
      chk_all($sformatf("%s.c%0d", tag, k), 1'b1, 1'b0, vexp, exp_yes, exp_no);
    end

    start    = 1'($urandom_range(0, 1));
    vote_en  = 4'($urandom);
    vote_val = 4'($urandom);
    tick();
    exp_yes   = ny;
    exp_no    = nn;
    exp_voted = fin;
    chk_all({tag, ".done"}, 1'b0, 1'b1, exp_voted, exp_yes, exp_no);

    start    = 1'($urandom_range(0, 1));
    vote_en  = 4'($urandom);
    vote_val = 4'($urandom);
    tick();
    chk_all({tag, ".idle"}, 1'b0, 1'b0, exp_voted, exp_yes, exp_no);

    start    = 1'b0;
    vote_en  = 4'($urandom);
    vote_val = 4'($urandom);
    if (extra_idle) begin
      tick();
      chk_all({tag, ".idle2"}, 1'b0, 1'b0, exp_voted, exp_yes, exp_no);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    vote_en  = 4'b0000;
    vote_val = 4'b0000;
    #3;
    chk_all("reset", 1'b0, 1'b0, 4'b0000, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk_all("post_reset", 1'b0, 1'b0, 4'b0000, 0, 0);

    // Full turnout in the first OPEN cycle.
    clear_seq();
    en_seq[0]  = 4'b1111;
    val_seq[0] = 4'b1011;
    run_session("full", 1'b1);
    chk("full.yes3", 8'(yes_cnt), 8'd3);

    // Tie, one voter per cycle.
    clear_seq();
    en_seq[0] = 4'b0001; val_seq[0] = 4'b0001;
    en_seq[1] = 4'b0010; val_seq[1] = 4'b0000;
    en_seq[2] = 4'b0100; val_seq[2] = 4'b0100;
    en_seq[3] = 4'b1000; val_seq[3] = 4'b0000;
    run_session("tie", 1'b1);
    chk("tie.flag", 8'(tie), 8'd1);

    // Timeout with two abstentions.
    clear_seq();
    en_seq[0] = 4'b0011; val_seq[0] = 4'b0011;
    run_session("timeout", 1'b1);
    chk("timeout.voted", 8'(voted), 8'h3);

    // Re-vote attempt and a late start pulse mid-window.
    clear_seq();
    en_seq[0] = 4'b0100; val_seq[0] = 4'b0100;
    en_seq[2] = 4'b0100; val_seq[2] = 4'b0000;
    st_seq[3] = 1'b1;
    en_seq[4] = 4'b0011; val_seq[4] = 4'b0000;
    en_seq[6] = 4'b1000; val_seq[6] = 4'b0000;
    run_session("revote", 1'b1);
    chk("revote.yes1", 8'(yes_cnt), 8'd1);

    // Reset in the middle of an OPEN window after two ballots.
    start = 1'b1;
    tick();
    start    = 1'b0;
    vote_en  = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_en  = 4'b0010; vote_val = 4'b0010;
    tick();
    vote_en  = 4'b0000;
    chk("rst_mid.pre_voted", 8'(voted), 8'h3);
    #2 rst = 1'b1;
    #1;
    exp_yes   = 0;
    exp_no    = 0;
    exp_voted = 4'b0000;
    chk_all("rst_mid.async", 1'b0, 1'b0, 4'b0000, 0, 0);
    tick();
    chk_all("rst_mid.held", 1'b0, 1'b0, 4'b0000, 0, 0);
    #2 rst = 1'b0;
    tick();
    chk_all("rst_mid.idle1", 1'b0, 1'b0, 4'b0000, 0, 0);
    tick();
    chk_all("rst_mid.idle2", 1'b0, 1'b0, 4'b0000, 0, 0);
    clear_seq();
    en_seq[0]  = 4'b1111;
    val_seq[0] = 4'b0001;
    run_session("after_rst", 1'b0);

    // Back-to-back: start in the IDLE cycle right after done.
    clear_seq();
    en_seq[1] = 4'b1111; val_seq[1] = 4'b1110;
    run_session("b2b", 1'b0);

    // Randomized sessions, sparse strobes so timeouts occur too.
    for (int r = 0; r < 25; r++) begin
      clear_seq();
      for (int k = 0; k < TO; k++) begin
        en_seq[k]  = 4'($urandom) & 4'($urandom) & 4'($urandom);
        val_seq[k] = 4'($urandom);
        st_seq[k]  = ($urandom_range(0, 7) == 0);
      end
      run_session($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
